// File: rtl/regfile_param_if.sv
// Bundles the register file request/response signals between decode/writeback and the array.
// master drives addresses, write data and Clear; slave returns read data, WriteAccepted and Busy.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  Clear;
  logic                  RegWrite;
  logic [DATA_W/8-1:0]   WriteStrobe;
  logic [ADDR_W-1:0]     WriteRegister;
  logic [DATA_W-1:0]     WriteData;
  logic [ADDR_W-1:0]     ReadRegister1;
  logic [ADDR_W-1:0]     ReadRegister2;
  logic [DATA_W-1:0]     DataRead1;
  logic [DATA_W-1:0]     DataRead2;
  logic                  WriteAccepted;
  logic                  Busy;

  modport master (
    output Clear, RegWrite, WriteStrobe, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    input  DataRead1, DataRead2, WriteAccepted, Busy
  );

  modport slave (
    input  Clear, RegWrite, WriteStrobe, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    output DataRead1, DataRead2, WriteAccepted, Busy
  );
endinterface

// File: rtl/regfile_param.sv
// 2R/1W register file with byte strobes, write bypass and a one-register-per-cycle clear walk.
// Reads are 0-cycle combinational; writes arriving while Busy are dropped (WriteAccepted=0).
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic            Clk,
  input logic            Rst,
  regfile_param_if.slave rf
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam int                NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] FIRST = ZERO_REG ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              accept;
  logic [DATA_W-1:0] merged;

  assign busy   = (state_q == CLEARING);
  assign accept = rf.RegWrite & ~busy
                & ~(ZERO_REG & (rf.WriteRegister == '0))
                & (|rf.WriteStrobe);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= CLEARING;
      idx_q   <= FIRST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear is only honoured from IDLE; a walk in progress is never restarted or extended.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (rf.Clear) begin
          state_d = CLEARING;
          idx_d   = FIRST;
        end
      end
      CLEARING: begin
        if (idx_q == LAST) state_d = IDLE;
        else               idx_d   = idx_q + ADDR_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The array has no reset; the clear walk is what brings it to zero.
  always_ff @(posedge Clk) begin
    if (busy) begin
      mem[idx_q] <= '0;
    end else if (accept) begin
      for (int b = 0; b < NB; b++) begin
        if (rf.WriteStrobe[b]) mem[rf.WriteRegister][8*b +: 8] <= rf.WriteData[8*b +: 8];
      end
    end
  end

  always_comb begin
    merged = mem[rf.WriteRegister];
    for (int b = 0; b < NB; b++) begin
      if (rf.WriteStrobe[b]) merged[8*b +: 8] = rf.WriteData[8*b +: 8];
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (busy)                                            return '0;
    else if (ZERO_REG && addr == '0)                     return '0;
    else if (BYPASS && accept && addr == rf.WriteRegister) return merged;
    else                                                 return mem[addr];
  endfunction

  assign rf.DataRead1     = read_port(rf.ReadRegister1);
  assign rf.DataRead2     = read_port(rf.ReadRegister2);
  assign rf.WriteAccepted = accept;
  assign rf.Busy          = busy;
endmodule

// File: tb/tb_regfile_param.sv
// Drives a default instance and a ZERO_REG=0/BYPASS=0 instance in lockstep against a
// behavioural model (busy countdown, whole-array wipe at clear start, byte-merge writes).
module tb_regfile_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) a0 ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .Clk(Clk), .Rst(Rst), .rf(a0.slave));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .Clk(Clk), .Rst(Rst), .rf(a1.slave));

  int tests = 0;
  int fails = 0;

  logic          clr, rw;
  logic [3:0]    strb, wa, ra1, ra2;
  logic [31:0]   wd;
  logic [31:0]   mdl [2][DEPTH];
  int            bl [2];

  function automatic bit zr(input int d);   return d == 0; endfunction
  function automatic bit bp(input int d);   return d == 0; endfunction
  function automatic int walk(input int d); return zr(d) ? 15 : 16; endfunction

  function automatic logic [31:0] mrg(input int d);
    logic [31:0] r;
    r = mdl[d][wa];
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rdm(input int d, input logic [3:0] a, input bit busy,
                                      input bit acc, input logic [31:0] mg);
    if (busy)                         return 32'h0;
    if (zr(d) && a == 4'd0)           return 32'h0;
    if (bp(d) && acc && a == wa)      return mg;
    return mdl[d][a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      bl[d] = walk(d);
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
    end
  endtask

  task automatic drive();
    a0.Clear = clr; a0.RegWrite = rw; a0.WriteStrobe = strb; a0.WriteRegister = wa;
    a0.WriteData = wd; a0.ReadRegister1 = ra1; a0.ReadRegister2 = ra2;
    a1.Clear = clr; a1.RegWrite = rw; a1.WriteStrobe = strb; a1.WriteRegister = wa;
    a1.WriteData = wd; a1.ReadRegister1 = ra1; a1.ReadRegister2 = ra2;
  endtask

  // One clock: drive, check at negedge, then advance the model past the rising edge.
  task automatic step(input bit kc = 1'b0, input logic [31:0] k0 = 32'h0,
                      input logic [31:0] k1 = 32'h0);
    bit          acc [2];
    bit          busy;
    logic [31:0] mg;
    drive();
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      busy   = (bl[d] > 0);
      acc[d] = rw && !busy && !(zr(d) && wa == 4'd0) && (strb != 4'd0);
      mg     = mrg(d);
      chk($sformatf("busy_d%0d", d), 32'((d == 0) ? a0.Busy : a1.Busy), 32'(busy));
      chk($sformatf("wacc_d%0d", d),
          32'((d == 0) ? a0.WriteAccepted : a1.WriteAccepted), 32'(acc[d]));
      chk($sformatf("rd1_d%0d_r%0d", d, ra1), (d == 0) ? a0.DataRead1 : a1.DataRead1,
          rdm(d, ra1, busy, acc[d], mg));
      chk($sformatf("rd2_d%0d_r%0d", d, ra2), (d == 0) ? a0.DataRead2 : a1.DataRead2,
          rdm(d, ra2, busy, acc[d], mg));
    end
    if (kc) begin
      chk("const_rd1_d0", a0.DataRead1, k0);
      chk("const_rd1_d1", a1.DataRead1, k1);
    end
    @(posedge Clk);
    #1;
    if (Rst) begin
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) mdl[d][wa] = mrg(d);
        if (bl[d] > 0) bl[d]--;
        else if (clr) begin
          bl[d] = walk(d);
          for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
        end
      end
    end
  endtask

  initial begin
    clr = 1'b0; rw = 1'b0; strb = 4'h0; wa = 4'd0; wd = 32'h0; ra1 = 4'd0; ra2 = 4'd0;
    drive();
    Rst = 1'b1;
    #1 Rst = 1'b0;
    model_reset();

    // Reset state, with a write attempt that must be refused.
    rw = 1'b1; strb = 4'hF; wa = 4'd2; wd = 32'h12345678; ra1 = 4'd2; ra2 = 4'd0;
    repeat (3) step(1'b1, 32'h0, 32'h0);
    Rst = 1'b1;

    // Reset walk with writes hammering during Busy.
    for (int i = 0; i < 16; i++) begin
      rw = (i < 15); wa = 4'($urandom); ra1 = wa; ra2 = 4'($urandom); wd = $urandom;
      step();
    end
    rw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 4'(2 * i); ra2 = 4'(2 * i + 1);
      step(1'b1, 32'h0, 32'h0);
    end

    // Byte strobe merge.
    rw = 1'b1; wa = 4'd5; strb = 4'hF; wd = 32'hAABBCCDD; ra1 = 4'd0; ra2 = 4'd5;
    step();
    strb = 4'b0101; wd = 32'h11223344;
    step();
    rw = 1'b0; ra1 = 4'd5;
    step(1'b1, 32'hAA22CC44, 32'hAA22CC44);

    // Same-cycle bypass versus old value.
    rw = 1'b1; wa = 4'd7; strb = 4'hF; wd = 32'hDEADBEEF; ra1 = 4'd7;
    step(1'b1, 32'hDEADBEEF, 32'h0);
    rw = 1'b0;
    step(1'b1, 32'hDEADBEEF, 32'hDEADBEEF);

    // Register 0 behaviour.
    rw = 1'b1; wa = 4'd0; wd = 32'hFFFFFFFF; ra1 = 4'd0;
    step(1'b1, 32'h0, 32'h0);
    rw = 1'b0;
    step(1'b1, 32'h0, 32'hFFFFFFFF);

    // Clear request coinciding with a write.
    strb = 4'hF; rw = 1'b1;
    for (int i = 1; i < 16; i++) begin
      wa = 4'(i); wd = 32'(i); ra1 = 4'(i - 1); ra2 = 4'($urandom);
      step();
    end
    clr = 1'b1; wa = 4'd3; wd = 32'h55; ra1 = 4'd3;
    step(1'b1, 32'h55, 32'h3);
    clr = 1'b0; rw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra2 = 4'($urandom);
      step(1'b1, 32'h0, 32'h0);
    end
    rw = 1'b1; wa = 4'd3; wd = 32'h66;
    step();
    rw = 1'b0;
    step(1'b1, 32'h66, 32'h66);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 49) == 0);
      rw   = 1'($urandom);
      strb = 4'($urandom);
      wa   = 4'($urandom);
      wd   = $urandom;
      ra1  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      ra2  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      step();
    end
    clr = 1'b0; rw = 1'b0;
    repeat (17) step();

    // Reset dropped part-way through a clear walk.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    Rst = 1'b0;
    model_reset();
    rw = 1'b1; strb = 4'hF; wa = 4'd9; wd = 32'hCAFEF00D; ra1 = 4'd9;
    repeat (2) step(1'b1, 32'h0, 32'h0);
    Rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rw = (i < 15); wa = 4'($urandom); wd = $urandom; ra1 = 4'($urandom); ra2 = wa;
      step();
    end
    rw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 4'(2 * i); ra2 = 4'(2 * i + 1);
      step(1'b1, 32'h0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
